// File: rtl/conv_lane_scheduler.sv
// conv_lane_scheduler
//   Frame-level sequencer for a P-lane parallel convolver. It loads LENX input
//   samples into the x memories. It then steps P MAC lanes through
//   ceil(SIZE/P) output groups, where SIZE = LENX-LENF+1. For each group it
//   issues LENF taps, spends one tail cycle absorbing the 1-cycle read latency,
//   and makes one group write into the output buffer.
//
// Ports
//   clk, reset  : clock; asynchronous active-high reset
//   s_valid_x   : input sample valid
//   s_ready_x   : input ready (LOAD only)
//   x_wr_en     : x memory write strobe (handshake)
//   x_wr_addr   : x memory write address (load count)
//   x_rd_addr   : per-lane x read address, lane i at [i*ADDRX +: ADDRX]
//   f_rd_addr   : filter ROM tap address
//   clr_acc     : per-lane accumulator clear (first tap of a group)
//   en_acc      : per-lane accumulate enable (data of previous tap)
//   y_wr_en     : output buffer group write
//   y_wr_addr   : group base index
//   y_wr_mask   : lanes holding a valid result in this group
//   y_ready     : output buffer can accept a group
//   frame_done  : 1-cycle pulse with the last group write of a frame
module conv_lane_scheduler #(
  parameter int LENX  = 8,
  parameter int LENF  = 4,
  parameter int P     = 2,
  parameter int ADDRX = 3,
  parameter int ADDRF = 2,
  parameter int ADDRY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid_x,
  output logic               s_ready_x,
  output logic               x_wr_en,
  output logic [ADDRX-1:0]   x_wr_addr,
  output logic [P*ADDRX-1:0] x_rd_addr,
  output logic [ADDRF-1:0]   f_rd_addr,
  output logic [P-1:0]       clr_acc,
  output logic [P-1:0]       en_acc,
  output logic               y_wr_en,
  output logic [ADDRY-1:0]   y_wr_addr,
  output logic [P-1:0]       y_wr_mask,
  input  logic               y_ready,
  output logic               frame_done
);

  localparam int SIZE = LENX - LENF + 1;
  // One extra bit so base can step past SIZE without wrapping.
  localparam int CW   = ADDRX + 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_TAIL,
    S_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    base_q, base_d;
  logic [ADDRF-1:0] k_q, k_d;

  logic [P-1:0]     mask;
  logic [CW-1:0]    base_next;
  logic             last_group;

  assign base_next  = base_q + CW'(P);
  assign last_group = (base_next >= CW'(SIZE));

  // Lane i holds a real output only while base+i is inside the result range.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < P; i++) begin
      mask[i] = ((base_q + CW'(i)) < CW'(SIZE));
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      base_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    k_d     = k_q;
    unique case (state_q)
      S_LOAD: begin
        if (s_valid_x) begin
          if (cnt_q == CW'(LENX - 1)) begin
            state_d = S_ISSUE;
            cnt_d   = '0;
            base_d  = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ISSUE: begin
        // k stays at the last tap so TAIL keeps presenting the same addresses.
        if (k_q == ADDRF'(LENF - 1)) begin
          state_d = S_TAIL;
        end else begin
          k_d = k_q + ADDRF'(1);
        end
      end
      S_TAIL: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (y_ready) begin
          if (last_group) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            base_d  = '0;
            k_d     = '0;
          end else begin
            state_d = S_ISSUE;
            base_d  = base_next;
            k_d     = '0;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
        base_d  = '0;
        k_d     = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    s_ready_x  = 1'b0;
    x_wr_en    = 1'b0;
    x_wr_addr  = '0;
    x_rd_addr  = '0;
    f_rd_addr  = '0;
    clr_acc    = '0;
    en_acc     = '0;
    y_wr_en    = 1'b0;
    y_wr_addr  = '0;
    y_wr_mask  = '0;
    frame_done = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        s_ready_x = 1'b1;
        x_wr_en   = s_valid_x;
        x_wr_addr = cnt_q[ADDRX-1:0];
      end
      S_ISSUE, S_TAIL: begin
        f_rd_addr = k_q;
        for (int unsigned i = 0; i < P; i++) begin
          if (mask[i]) begin
            x_rd_addr[i*ADDRX +: ADDRX] = ADDRX'(base_q + CW'(i) + CW'(k_q));
          end
        end
        if (state_q == S_TAIL) begin
          en_acc = mask;
        end else if (k_q == '0) begin
          clr_acc = '1;
        end else begin
          // Read data for tap k-1 arrives while tap k is issued.
          en_acc = mask;
        end
      end
      S_WRITE: begin
        y_wr_en    = y_ready;
        y_wr_addr  = ADDRY'(base_q);
        y_wr_mask  = mask;
        frame_done = y_ready & last_group;
      end
      default: begin
        s_ready_x = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_lane_scheduler.sv
module tb_conv_lane_scheduler;

  localparam int LENX  = 8;
  localparam int LENF  = 4;
  localparam int P     = 2;
  localparam int ADDRX = 3;
  localparam int ADDRF = 2;
  localparam int ADDRY = 3;
  localparam int SIZE  = LENX - LENF + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid_x;
  logic               s_ready_x;
  logic               x_wr_en;
  logic [ADDRX-1:0]   x_wr_addr;
  logic [P*ADDRX-1:0] x_rd_addr;
  logic [ADDRF-1:0]   f_rd_addr;
  logic [P-1:0]       clr_acc;
  logic [P-1:0]       en_acc;
  logic               y_wr_en;
  logic [ADDRY-1:0]   y_wr_addr;
  logic [P-1:0]       y_wr_mask;
  logic               y_ready;
  logic               frame_done;

  conv_lane_scheduler #(
    .LENX (LENX),
    .LENF (LENF),
    .P    (P),
    .ADDRX(ADDRX),
    .ADDRF(ADDRF),
    .ADDRY(ADDRY)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .x_wr_en   (x_wr_en),
    .x_wr_addr (x_wr_addr),
    .x_rd_addr (x_rd_addr),
    .f_rd_addr (f_rd_addr),
    .clr_acc   (clr_acc),
    .en_acc    (en_acc),
    .y_wr_en   (y_wr_en),
    .y_wr_addr (y_wr_addr),
    .y_wr_mask (y_wr_mask),
    .y_ready   (y_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is "loading m_ld samples" or "group m_g, cycle
  // m_pos of LENF+2", where pos 0..LENF-1 issue taps, LENF is the tail and
  // LENF+1 is the write slot (held while y_ready is low).
  bit m_load = 1'b1;
  int m_ld   = 0;
  int m_g    = 0;
  int m_pos  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load <= 1'b1;
      m_ld   <= 0;
      m_g    <= 0;
      m_pos  <= 0;
    end else if (m_load) begin
      if (s_valid_x) begin
        if (m_ld == LENX - 1) begin
          m_load <= 1'b0;
          m_g    <= 0;
          m_pos  <= 0;
        end
        m_ld <= (m_ld == LENX - 1) ? 0 : m_ld + 1;
      end
    end else if (m_pos < LENF + 1) begin
      m_pos <= m_pos + 1;
    end else if (y_ready) begin
      m_pos <= 0;
      if ((m_g + 1) * P >= SIZE) begin
        m_load <= 1'b1;
        m_g    <= 0;
      end else begin
        m_g <= m_g + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic               e_rdy, e_wen, e_ywe, e_fd;
    logic [ADDRX-1:0]   e_wa;
    logic [P*ADDRX-1:0] e_xrd;
    logic [ADDRF-1:0]   e_f;
    logic [P-1:0]       e_clr, e_en, e_ym, e_mask;
    logic [ADDRY-1:0]   e_ya;
    int                 base, tap;
    e_rdy = 0; e_wen = 0; e_ywe = 0; e_fd = 0; e_wa = '0; e_xrd = '0;
    e_f = '0; e_clr = '0; e_en = '0; e_ym = '0; e_ya = '0; e_mask = '0;
    base = m_g * P;
    tap  = (m_pos < LENF) ? m_pos : LENF - 1;
    for (int i = 0; i < P; i++) e_mask[i] = (base + i < SIZE);
    if (m_load) begin
      e_rdy = 1'b1;
      e_wen = s_valid_x;
      e_wa  = ADDRX'(m_ld);
    end else if (m_pos <= LENF) begin
      e_f = ADDRF'(tap);
      for (int i = 0; i < P; i++)
        if (e_mask[i]) e_xrd[i*ADDRX +: ADDRX] = ADDRX'(base + i + tap);
      if (m_pos == 0) e_clr = '1;
      else            e_en  = e_mask;
    end else begin
      e_ywe = y_ready;
      e_ya  = ADDRY'(base);
      e_ym  = e_mask;
      e_fd  = y_ready && (base + P >= SIZE);
    end
    chk("s_ready_x",  s_ready_x,  e_rdy);
    chk("x_wr_en",    x_wr_en,    e_wen);
    chk("x_wr_addr",  x_wr_addr,  e_wa);
    chk("x_rd_addr",  x_rd_addr,  e_xrd);
    chk("f_rd_addr",  f_rd_addr,  e_f);
    chk("clr_acc",    clr_acc,    e_clr);
    chk("en_acc",     en_acc,     e_en);
    chk("y_wr_en",    y_wr_en,    e_ywe);
    chk("y_wr_addr",  y_wr_addr,  e_ya);
    chk("y_wr_mask",  y_wr_mask,  e_ym);
    chk("frame_done", frame_done, e_fd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Eight back-to-back samples; returns one cycle after the last handshake.
  task automatic load_b2b();
    s_valid_x = 1'b1;
    for (int i = 0; i < LENX; i++) begin
      @(negedge clk);
      chk("load_addr", x_wr_addr, i);
      tick();
    end
    s_valid_x = 1'b0;
  endtask

  // Counts cycles (from the current one) and writes until frame_done; realigns to posedge+1.
  task automatic wait_done(input int bound, output int n, output int writes);
    bit seen = 0;
    n = 0;
    writes = 0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (y_wr_en) writes++;
      if (frame_done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", bound);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, vp, rp;
    bit done;
    logic [ADDRY-1:0] wa [3];
    logic [P-1:0]     wm [3];

    rst = 1'b1; s_valid_x = 1'b0; y_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_ready", s_ready_x, 1);
    chk("reset_en",    en_acc,    0);

    // Back-to-back frame with literal expectations along the way.
    y_ready = 1'b1;
    load_b2b();
    n = 0; w = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1)  chk("g0_clr", clr_acc, 2'b11);
      if (n == 2)  begin chk("g0_xrd_k1", x_rd_addr, 6'b010_001); chk("g0_en_k1", en_acc, 2'b11); end
      if (n == 4)  chk("g0_f_k3", f_rd_addr, 3);
      if (n == 13) chk("g2_xrd_k0", x_rd_addr, 6'b000_100);
      if (n == 14) chk("g2_en_k1", en_acc, 2'b01);
      if (y_wr_en && w < 3) begin wa[w] = y_wr_addr; wm[w] = y_wr_mask; w++; end
      if (frame_done) done = 1;
    end
    chk("done_latency", n, 18);
    chk("group_writes", w, 3);
    chk("w0_addr", wa[0], 0); chk("w0_mask", wm[0], 2'b11);
    chk("w1_addr", wa[1], 2); chk("w1_mask", wm[1], 2'b11);
    chk("w2_addr", wa[2], 4); chk("w2_mask", wm[2], 2'b01);
    tick();
    chk("b2b_ready", s_ready_x, 1);

    // Output buffer stall in the first WRITE.
    y_ready = 1'b0;
    load_b2b();
    repeat (5) tick();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_wen",  y_wr_en,   0);
      chk("stall_addr", y_wr_addr, 0);
      chk("stall_mask", y_wr_mask, 2'b11);
      chk("stall_en",   en_acc,    0);
      tick();
    end
    y_ready = 1'b1;
    wait_done(60, n, w);
    chk("stall_writes", w, 3);

    // Toggling valid: handshakes on even cycles only.
    s_valid_x = 1'b1;
    for (int c = 0; c < 15; c++) begin
      s_valid_x = (c % 2 == 0);
      if (c == 5) begin
        @(negedge clk);
        chk("toggle_addr", x_wr_addr, 3);
      end
      tick();
    end
    s_valid_x = 1'b0;
    @(negedge clk);
    chk("toggle_issue_ready", s_ready_x, 0);
    chk("toggle_issue_clr",   clr_acc,   2'b11);
    wait_done(60, n, w);

    // Asynchronous reset between edges during ISSUE of group 1.
    load_b2b();
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", s_ready_x, 1);
    chk("async_rst_en",    en_acc,    0);
    chk("async_rst_clr",   clr_acc,   0);
    chk("async_rst_ywe",   y_wr_en,   0);
    chk("async_rst_xrd",   x_rd_addr, 0);
    tick();
    rst = 1'b0;
    load_b2b();
    wait_done(60, n, w);
    chk("post_rst_latency", n, 18);
    chk("post_rst_writes",  w, 3);

    // Randomized frames, with an occasional mid-frame reset.
    for (int f = 0; f < 30; f++) begin
      vp = $urandom_range(30, 100);
      rp = $urandom_range(20, 100);
      done = 0;
      n = 0;
      while (!done && n < 400) begin
        s_valid_x = ($urandom_range(0, 99) < vp);
        y_ready   = ($urandom_range(0, 99) < rp);
        if (f % 7 == 3 && n == 12) begin
          #2 rst = 1'b1;
        end
        @(negedge clk);
        if (frame_done) done = 1;
        tick();
        rst = 1'b0;
        n++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_frame_timeout: got none expected frame_done in frame %0d", f);
      end
    end

    s_valid_x = 1'b0;
    y_ready   = 1'b0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
